// File: rtl/philv_mem_arbiter_pkg.sv
// Shared types and constants for the Philosophy V unified-RAM arbiter.
package philv_mem_pkg;

  // Arbiter transaction phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Requester identity; the value doubles as the bit index in req/gnt vectors.
  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  localparam int MAX_MEM_LATENCY = 4;
  localparam int BE_W            = 4;
  // Counter only ever holds MEM_LATENCY-1, so it never needs to reach MAX_MEM_LATENCY.
  localparam int LAT_CNT_W       = $clog2(MAX_MEM_LATENCY);

  // Keeps an out-of-range latency parameter inside the supported 1..MAX window.
  function automatic int clamp_latency(input int lat);
    if (lat < 1) begin
      return 1;
    end
    if (lat > MAX_MEM_LATENCY) begin
      return MAX_MEM_LATENCY;
    end
    return lat;
  endfunction

endpackage

// File: rtl/philv_mem_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the RAM port.
// slave  : the arbiter's view.
// master : the core-plus-RAM view.
interface philv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Fetch port
  logic                          if_req;
  logic [ADDR_W-1:0]             if_addr;
  logic                          if_gnt;
  logic                          if_rvalid;
  logic [DATA_W-1:0]             if_rdata;

  // Load/store port
  logic                          mem_req;
  logic                          mem_we;
  logic [philv_mem_pkg::BE_W-1:0] mem_be;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic                          mem_gnt;
  logic                          mem_rvalid;
  logic [DATA_W-1:0]             mem_rdata;

  // RAM port
  logic                          ram_en;
  logic [philv_mem_pkg::BE_W-1:0] ram_we;
  logic [ADDR_W-1:0]             ram_addr;
  logic [DATA_W-1:0]             ram_wdata;
  logic [DATA_W-1:0]             ram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/philv_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Purely combinational; the parent keeps
// last_owner. On a conflict the port that did not own the previous
// transaction wins.
module philv_rr_arb2
  import philv_mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last_owner,
  input  logic       enable,
  output logic [1:0] gnt
);

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_gnt
    // A port wins when it asks alone, or when it asks and was not the last owner.
    assign gnt[gi] = enable & req[gi] &
                     (~req[1-gi] | (last_owner != req_id_e'(gi)));
  end

endmodule

// File: rtl/philv_mem_arbiter.sv
// Shares one single-ported RAM between the fetch and load/store ports.
// One transaction in flight; a transaction spans MEM_LATENCY+2 cycles:
// grant (IDLE), RAM strobe (ISSUE), MEM_LATENCY-1 WAIT cycles, response (RESP).
module philv_mem_arbiter
  import philv_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rstb,
  philv_mem_arbiter_if.slave bus
);

  localparam int                   LAT      = clamp_latency(MEM_LATENCY);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT - 1);

  state_e                 state_reg, state_next;
  logic [LAT_CNT_W-1:0]   cnt_reg, cnt_next;
  req_id_e                owner_reg, owner_next;
  req_id_e                last_owner_reg, last_owner_next;
  // Byte-offset bits are dropped at capture: the RAM is word-addressed.
  logic [ADDR_W-3:0]      addr_reg, addr_next;
  logic                   we_reg, we_next;
  logic [BE_W-1:0]        be_reg, be_next;
  logic [DATA_W-1:0]      wdata_reg, wdata_next;

  logic [1:0]             req_vec;
  logic [1:0]             gnt_vec;
  logic                   arb_en;

  assign req_vec = {bus.mem_req, bus.if_req};
  // Grants only exist while idle and never during reset.
  assign arb_en  = (state_reg == IDLE) && !rstb;

  philv_rr_arb2 u_arb (
    .req        (req_vec),
    .last_owner (last_owner_reg),
    .enable     (arb_en),
    .gnt        (gnt_vec)
  );

  assign bus.if_gnt  = gnt_vec[REQ_IF];
  assign bus.mem_gnt = gnt_vec[REQ_MEM];

  // State, latency counter and captured transaction registers.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      owner_reg      <= REQ_IF;
      last_owner_reg <= REQ_IF;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      be_reg         <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      be_reg         <= be_next;
      wdata_reg      <= wdata_next;
    end
  end

  // Next-state logic: capture on grant, then walk ISSUE -> WAIT* -> RESP.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    addr_next       = addr_reg;
    we_next         = we_reg;
    be_next         = be_reg;
    wdata_next      = wdata_reg;

    unique case (state_reg)
      IDLE: begin
        if (gnt_vec[REQ_MEM]) begin
          owner_next      = REQ_MEM;
          last_owner_next = REQ_MEM;
          addr_next       = bus.mem_addr[ADDR_W-1:2];
          we_next         = bus.mem_we;
          be_next         = bus.mem_be;
          wdata_next      = bus.mem_wdata;
          state_next      = ISSUE;
        end else if (gnt_vec[REQ_IF]) begin
          // Fetches are always reads; clear the store fields outright.
          owner_next      = REQ_IF;
          last_owner_next = REQ_IF;
          addr_next       = bus.if_addr[ADDR_W-1:2];
          we_next         = 1'b0;
          be_next         = '0;
          wdata_next      = '0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = LAT_LOAD;
        state_next = (LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end
        if (cnt_reg <= LAT_CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM strobe and response outputs; everything is held at zero during reset.
  always_comb begin
    bus.ram_en     = 1'b0;
    bus.ram_we     = '0;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
    bus.if_rvalid  = 1'b0;
    bus.if_rdata   = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    if (!rstb) begin
      unique case (state_reg)
        ISSUE: begin
          bus.ram_en    = 1'b1;
          bus.ram_addr  = {addr_reg, 2'b00};
          bus.ram_we    = (we_reg && owner_reg == REQ_MEM) ? be_reg : '0;
          bus.ram_wdata = wdata_reg;
        end
        RESP: begin
          if (owner_reg == REQ_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.ram_rdata;
          end else begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = we_reg ? '0 : bus.ram_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_philv_mem_arbiter.sv
// Bench for philv_mem_arbiter: two instances (MEM_LATENCY 1 and 3) share one
// RAM array; `sel` routes the stimulus to one of them at a time.
module tb_philv_mem_arbiter;
  import philv_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        sel;
  int          lat;
  int          checks;
  int          errors;

  logic        c_if_req;
  logic [31:0] c_if_addr;
  logic        c_mem_req;
  logic        c_mem_we;
  logic [3:0]  c_mem_be;
  logic [31:0] c_mem_addr;
  logic [31:0] c_mem_wdata;

  philv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  philv_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  philv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rstb(rstb), .bus(b1));
  philv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rstb(rstb), .bus(b3));

  assign b1.if_req    = !sel && c_if_req;
  assign b3.if_req    =  sel && c_if_req;
  assign b1.mem_req   = !sel && c_mem_req;
  assign b3.mem_req   =  sel && c_mem_req;
  assign b1.if_addr   = c_if_addr;
  assign b3.if_addr   = c_if_addr;
  assign b1.mem_we    = c_mem_we;
  assign b3.mem_we    = c_mem_we;
  assign b1.mem_be    = c_mem_be;
  assign b3.mem_be    = c_mem_be;
  assign b1.mem_addr  = c_mem_addr;
  assign b3.mem_addr  = c_mem_addr;
  assign b1.mem_wdata = c_mem_wdata;
  assign b3.mem_wdata = c_mem_wdata;

  // Observed outputs of the selected instance.
  logic        o_if_gnt, o_if_rvalid, o_mem_gnt, o_mem_rvalid, o_ram_en;
  logic [31:0] o_if_rdata, o_mem_rdata, o_ram_addr, o_ram_wdata;
  logic [3:0]  o_ram_we;
  logic [136:0] o_all;
  assign o_if_gnt     = sel ? b3.if_gnt     : b1.if_gnt;
  assign o_if_rvalid  = sel ? b3.if_rvalid  : b1.if_rvalid;
  assign o_if_rdata   = sel ? b3.if_rdata   : b1.if_rdata;
  assign o_mem_gnt    = sel ? b3.mem_gnt    : b1.mem_gnt;
  assign o_mem_rvalid = sel ? b3.mem_rvalid : b1.mem_rvalid;
  assign o_mem_rdata  = sel ? b3.mem_rdata  : b1.mem_rdata;
  assign o_ram_en     = sel ? b3.ram_en     : b1.ram_en;
  assign o_ram_we     = sel ? b3.ram_we     : b1.ram_we;
  assign o_ram_addr   = sel ? b3.ram_addr   : b1.ram_addr;
  assign o_ram_wdata  = sel ? b3.ram_wdata  : b1.ram_wdata;
  assign o_all = {o_if_gnt, o_if_rvalid, o_if_rdata, o_mem_gnt, o_mem_rvalid,
                  o_mem_rdata, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata};

  // RAM model: byte-lane writes, read data delayed by the instance's latency.
  logic [31:0] ram_mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] p1;
  logic [31:0] p3 [0:2];
  always @(posedge clk) begin
    p1    <= b1.ram_en ? ram_mem[b1.ram_addr[11:2]] : 32'hBAD0BAD0;
    p3[0] <= b3.ram_en ? ram_mem[b3.ram_addr[11:2]] : 32'hBAD0BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    for (int k = 0; k < 4; k++) begin
      if (b1.ram_en && b1.ram_we[k]) ram_mem[b1.ram_addr[11:2]][8*k +: 8] <= b1.ram_wdata[8*k +: 8];
      if (b3.ram_en && b3.ram_we[k]) ram_mem[b3.ram_addr[11:2]][8*k +: 8] <= b3.ram_wdata[8*k +: 8];
    end
  end
  assign b1.ram_rdata = p1;
  assign b3.ram_rdata = p3[2];

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    w = i;
    if (i == 16) return 32'h0000_0013;
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [9:0] w;
    logic [1:0] b;
    w = 10'($urandom_range(0, 1023));
    b = 2'($urandom_range(0, 3));
    return {20'd0, w, b};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    c_if_req  = 1'b0;
    c_mem_req = 1'b0;
    repeat (n) begin
      next_cycle();
      sample();
    end
  endtask

  task automatic apply_reset(input logic s);
    c_if_req = 0; c_if_addr = 0; c_mem_req = 0; c_mem_we = 0;
    c_mem_be = 0; c_mem_addr = 0; c_mem_wdata = 0;
    sel = s;
    lat = s ? 3 : 1;
    next_cycle(); rstb = 1'b1;
    next_cycle(); rstb = 1'b0;
    sample();
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); lat = s ? 3 : 1;
      c_if_req = 0; c_mem_req = 0;
      next_cycle(); rstb = 1'b1;
      sample();
      checks++;
      if (o_all !== '0) begin errors++; $display("FAIL reset_outputs_in_reset: sel=%0d got %h required 0", s, o_all); end
      next_cycle(); rstb = 1'b0;
      sample();
      checks++;
      if (o_all !== '0) begin errors++; $display("FAIL reset_outputs_after: sel=%0d got %h required 0", s, o_all); end
      next_cycle(); c_if_req = 1; c_if_addr = 32'h40; c_mem_req = 1; c_mem_we = 0; c_mem_addr = 32'h200;
      sample();
      checks++;
      if ({o_mem_gnt, o_if_gnt} !== 2'b10) begin errors++; $display("FAIL reset_first_conflict: sel=%0d mem_gnt,if_gnt=%b required 10", s, {o_mem_gnt, o_if_gnt}); end
      drain(lat + 2);
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_single_fetch();
    apply_reset(1'b0);
    next_cycle(); c_if_req = 1; c_if_addr = 32'h40;
    sample();
    checks++;
    if ({o_if_gnt, o_mem_gnt, o_ram_en} !== 3'b100) begin errors++; $display("FAIL fetch_gnt: if_gnt,mem_gnt,ram_en=%b required 100", {o_if_gnt, o_mem_gnt, o_ram_en}); end
    next_cycle(); c_if_req = 0;
    sample();
    checks++;
    if ({o_ram_en, o_ram_addr, o_ram_we, o_if_rvalid, o_mem_rvalid} !== {1'b1, 32'h40, 4'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL fetch_issue: en=%b addr=%h we=%b rv=%b/%b required en=1 addr=40 we=0 rv=0/0", o_ram_en, o_ram_addr, o_ram_we, o_if_rvalid, o_mem_rvalid);
    end
    next_cycle();
    sample();
    checks++;
    if ({o_if_rvalid, o_if_rdata, o_mem_rvalid} !== {1'b1, 32'h0000_0013, 1'b0}) begin
      errors++; $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h mem_rvalid=%b required 1 00000013 0", o_if_rvalid, o_if_rdata, o_mem_rvalid);
    end
    next_cycle();
    sample();
    checks++;
    if ({o_if_rvalid, o_mem_rvalid} !== 2'b00) begin errors++; $display("FAIL fetch_rvalid_pulse: rvalids=%b required 00", {o_if_rvalid, o_mem_rvalid}); end
    $display("test_single_fetch done: errors=%0d", errors);
  endtask

  task automatic test_store_load();
    logic [31:0] exp_word;
    apply_reset(1'b0);
    exp_word = {ref_mem[64][31:16], 16'hBEEF};
    next_cycle(); c_mem_req = 1; c_mem_we = 1; c_mem_be = 4'b0011; c_mem_addr = 32'h103; c_mem_wdata = 32'hDEAD_BEEF;
    sample();
    checks++;
    if (o_mem_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: mem_gnt=%b required 1", o_mem_gnt); end
    ref_mem[64] = exp_word;
    next_cycle(); c_mem_req = 0;
    sample();
    checks++;
    if ({o_ram_en, o_ram_addr, o_ram_we, o_ram_wdata} !== {1'b1, 32'h100, 4'b0011, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL store_issue: en=%b addr=%h we=%b wdata=%h required 1 100 0011 deadbeef", o_ram_en, o_ram_addr, o_ram_we, o_ram_wdata);
    end
    next_cycle();
    sample();
    checks++;
    if ({o_mem_rvalid, o_mem_rdata, o_ram_we, o_if_rvalid} !== {1'b1, 32'h0, 4'h0, 1'b0}) begin
      errors++; $display("FAIL store_ack: rvalid=%b rdata=%h ram_we=%b if_rvalid=%b required 1 0 0000 0", o_mem_rvalid, o_mem_rdata, o_ram_we, o_if_rvalid);
    end
    next_cycle(); c_mem_req = 1; c_mem_we = 0; c_mem_be = 0; c_mem_addr = 32'h100;
    sample();
    checks++;
    if (o_mem_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt: mem_gnt=%b required 1", o_mem_gnt); end
    next_cycle(); c_mem_req = 0;
    next_cycle();
    sample();
    checks++;
    if ({o_mem_rvalid, o_mem_rdata} !== {1'b1, exp_word}) begin
      errors++; $display("FAIL load_after_store: rvalid=%b rdata=%h required 1 %h", o_mem_rvalid, o_mem_rdata, exp_word);
    end
    $display("test_store_load done: errors=%0d", errors);
  endtask

  task automatic test_conflict(input logic s);
    int g_cyc [0:7];
    logic g_who [0:7];
    int gn;
    apply_reset(s);
    gn = 0;
    for (int cyc = 0; cyc < 3 * (lat + 2); cyc++) begin
      next_cycle(); c_if_req = 1; c_if_addr = 32'h40; c_mem_req = 1; c_mem_we = 0; c_mem_addr = 32'h200;
      sample();
      checks++;
      if ((o_if_gnt && o_mem_gnt) || (o_if_rvalid && o_mem_rvalid)) begin
        errors++; $display("FAIL conflict_exclusive: cyc=%0d gnt=%b%b rvalid=%b%b required never both", cyc, o_if_gnt, o_mem_gnt, o_if_rvalid, o_mem_rvalid);
      end
      if ((o_if_gnt || o_mem_gnt) && gn < 8) begin
        g_cyc[gn] = cyc; g_who[gn] = o_mem_gnt; gn++;
      end
    end
    checks++;
    if (gn != 3) begin
      errors++; $display("FAIL conflict_count: sel=%0d grants=%0d required 3", s, gn);
    end else begin
      checks++;
      if ({g_who[0], g_who[1], g_who[2]} !== 3'b101) begin
        errors++; $display("FAIL conflict_order: sel=%0d order(1=MEM)=%b%b%b required 101", s, g_who[0], g_who[1], g_who[2]);
      end
      checks++;
      if (g_cyc[0] != 0 || g_cyc[1] - g_cyc[0] != lat + 2 || g_cyc[2] - g_cyc[1] != lat + 2) begin
        errors++; $display("FAIL conflict_spacing: sel=%0d grant cycles %0d,%0d,%0d required 0,%0d,%0d", s, g_cyc[0], g_cyc[1], g_cyc[2], lat + 2, 2 * (lat + 2));
      end
    end
    drain(lat + 2);
    $display("test_conflict sel=%0d done: errors=%0d", s, errors);
  endtask

  task automatic test_latency3();
    logic [31:0] exp_word;
    apply_reset(1'b1);
    exp_word = ref_mem[128];
    next_cycle(); c_mem_req = 1; c_mem_we = 0; c_mem_addr = 32'h200;
    sample();
    checks++;
    if (o_mem_gnt !== 1'b1) begin errors++; $display("FAIL lat3_gnt: mem_gnt=%b required 1", o_mem_gnt); end
    next_cycle(); c_mem_req = 0;
    sample();
    checks++;
    if ({o_ram_en, o_ram_addr} !== {1'b1, 32'h200}) begin errors++; $display("FAIL lat3_issue: en=%b addr=%h required 1 200", o_ram_en, o_ram_addr); end
    for (int k = 2; k <= 4; k++) begin
      next_cycle(); c_mem_req = 1;
      sample();
      checks++;
      if ({o_mem_gnt, o_mem_rvalid} !== {1'b0, (k == 4) ? 1'b1 : 1'b0}) begin
        errors++; $display("FAIL lat3_busy: N+%0d mem_gnt=%b mem_rvalid=%b required 0 %0d", k, o_mem_gnt, o_mem_rvalid, k == 4);
      end
      if (k == 4) begin
        checks++;
        if (o_mem_rdata !== exp_word) begin errors++; $display("FAIL lat3_data: rdata=%h required %h", o_mem_rdata, exp_word); end
      end
    end
    next_cycle();
    sample();
    checks++;
    if (o_mem_gnt !== 1'b1) begin errors++; $display("FAIL lat3_regnt: mem_gnt=%b required 1 after RESP", o_mem_gnt); end
    drain(lat + 2);
    $display("test_latency3 done: errors=%0d", errors);
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b1);
    next_cycle(); c_if_req = 1; c_if_addr = 32'h40;
    sample();
    checks++;
    if (o_if_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: if_gnt=%b required 1", o_if_gnt); end
    next_cycle(); c_if_req = 0;
    next_cycle(); rstb = 1'b1;
    next_cycle(); rstb = 1'b0;
    sample();
    checks++;
    if (o_all !== '0) begin errors++; $display("FAIL rstmid_outputs: got %h required 0", o_all); end
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      sample();
      checks++;
      if ({o_if_rvalid, o_ram_en} !== 2'b00) begin errors++; $display("FAIL rstmid_no_resp: k=%0d if_rvalid=%b ram_en=%b required 00", k, o_if_rvalid, o_ram_en); end
    end
    next_cycle(); c_if_req = 1; c_mem_req = 1; c_mem_we = 0; c_mem_addr = 32'h200;
    sample();
    checks++;
    if ({o_mem_gnt, o_if_gnt} !== 2'b10) begin errors++; $display("FAIL rstmid_conflict: mem_gnt,if_gnt=%b required 10", {o_mem_gnt, o_if_gnt}); end
    drain(lat + 2);
    $display("test_reset_mid done: errors=%0d", errors);
  endtask

  task automatic test_drop();
    apply_reset(1'b0);
    next_cycle(); c_mem_req = 1; c_mem_we = 0; c_mem_addr = 32'h100;
    sample();
    next_cycle(); c_mem_req = 0; c_if_req = 1; c_if_addr = 32'h40;
    sample();
    checks++;
    if ({o_if_gnt, o_ram_en, o_ram_addr} !== {1'b0, 1'b1, 32'h100}) begin
      errors++; $display("FAIL drop_busy: if_gnt=%b en=%b addr=%h required 0 1 100", o_if_gnt, o_ram_en, o_ram_addr);
    end
    next_cycle(); c_if_req = 0;
    sample();
    checks++;
    if ({o_if_gnt, o_mem_rvalid, o_if_rvalid} !== 3'b010) begin
      errors++; $display("FAIL drop_resp: if_gnt,mem_rvalid,if_rvalid=%b required 010", {o_if_gnt, o_mem_rvalid, o_if_rvalid});
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      checks++;
      if ({o_if_gnt, o_ram_en, o_if_rvalid} !== 3'b000) begin
        errors++; $display("FAIL drop_no_txn: k=%0d if_gnt,ram_en,if_rvalid=%b required 000", k, {o_if_gnt, o_ram_en, o_if_rvalid});
      end
    end
    $display("test_drop done: errors=%0d", errors);
  endtask

  // Random traffic against a transaction-level model: who may be granted, when,
  // and what each response must carry, derived from the ports' request history.
  task automatic test_random(input logic s, input int ncyc);
    int next_free, e_en, e_rv, idx;
    logic r_last, e_owner, e_we, ig_seen, mg_seen, exp_ig, exp_mg;
    logic [31:0] e_addr, e_data, e_wd;
    logic [3:0] e_be;
    apply_reset(s);
    r_last = 1'b0; next_free = 0; e_en = -1; e_rv = -1;
    e_owner = 0; e_we = 0; e_addr = 0; e_data = 0; e_wd = 0; e_be = 0;
    ig_seen = 0; mg_seen = 0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      next_cycle();
      if (ig_seen || !c_if_req) begin
        c_if_req = ($urandom_range(0, 2) == 0);
        c_if_addr = rand_addr();
      end else if ($urandom_range(0, 19) == 0) begin
        c_if_req = 1'b0;
      end
      if (mg_seen || !c_mem_req) begin
        c_mem_req = ($urandom_range(0, 2) == 0);
        c_mem_addr = rand_addr();
        c_mem_we = 1'($urandom_range(0, 1));
        c_mem_be = 4'($urandom_range(0, 15));
        c_mem_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        c_mem_req = 1'b0;
      end
      sample();
      exp_ig = 0; exp_mg = 0;
      if (cyc >= next_free) begin
        if (c_if_req && c_mem_req) begin
          exp_mg = (r_last == 1'b0);
          exp_ig = (r_last == 1'b1);
        end else begin
          exp_ig = c_if_req;
          exp_mg = c_mem_req;
        end
      end
      checks++;
      if ({o_if_gnt, o_mem_gnt} !== {exp_ig, exp_mg}) begin
        errors++; $display("FAIL rand_gnt: sel=%0d cyc=%0d if,mem gnt=%b%b required %b%b", s, cyc, o_if_gnt, o_mem_gnt, exp_ig, exp_mg);
      end
      checks++;
      if (o_ram_en !== (cyc == e_en)) begin
        errors++; $display("FAIL rand_ram_en: sel=%0d cyc=%0d ram_en=%b required %b", s, cyc, o_ram_en, cyc == e_en);
      end else if (cyc == e_en) begin
        checks++;
        if (o_ram_addr !== e_addr || o_ram_we !== e_be || (e_we && o_ram_wdata !== e_wd)) begin
          errors++; $display("FAIL rand_ram_cmd: sel=%0d cyc=%0d addr=%h we=%b wdata=%h required %h %b %h", s, cyc, o_ram_addr, o_ram_we, o_ram_wdata, e_addr, e_be, e_wd);
        end
      end
      checks++;
      if ({o_if_rvalid, o_mem_rvalid} !== {(cyc == e_rv) && !e_owner, (cyc == e_rv) && e_owner}) begin
        errors++; $display("FAIL rand_rvalid: sel=%0d cyc=%0d if,mem rvalid=%b%b required %b%b", s, cyc, o_if_rvalid, o_mem_rvalid, (cyc == e_rv) && !e_owner, (cyc == e_rv) && e_owner);
      end else if (cyc == e_rv) begin
        checks++;
        if ((e_owner ? o_mem_rdata : o_if_rdata) !== e_data) begin
          errors++; $display("FAIL rand_rdata: sel=%0d cyc=%0d rdata=%h required %h", s, cyc, e_owner ? o_mem_rdata : o_if_rdata, e_data);
        end
      end
      ig_seen = o_if_gnt;
      mg_seen = o_mem_gnt;
      if (exp_ig || exp_mg) begin
        e_owner = exp_mg;
        e_en = cyc + 1; e_rv = cyc + 1 + lat; next_free = cyc + lat + 2;
        e_addr = exp_mg ? c_mem_addr : c_if_addr;
        e_addr[1:0] = 2'b00;
        e_we = exp_mg && c_mem_we;
        e_be = e_we ? c_mem_be : 4'h0;
        e_wd = c_mem_wdata;
        idx = int'(e_addr[11:2]);
        if (e_we) begin
          e_data = 32'h0;
          for (int k = 0; k < 4; k++) if (e_be[k]) ref_mem[idx][8*k +: 8] = e_wd[8*k +: 8];
        end else begin
          e_data = ref_mem[idx];
        end
        r_last = exp_mg;
      end
    end
    drain(lat + 2);
    $display("test_random sel=%0d done: errors=%0d", s, errors);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rstb = 1'b1; sel = 1'b0; lat = 1;
    c_if_req = 0; c_if_addr = 0; c_mem_req = 0; c_mem_we = 0;
    c_mem_be = 0; c_mem_addr = 0; c_mem_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] <= init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (2) @(posedge clk);
    test_reset();
    test_single_fetch();
    test_store_load();
    test_conflict(1'b0);
    test_conflict(1'b1);
    test_latency3();
    test_reset_mid();
    test_drop();
    test_random(1'b0, 400);
    test_random(1'b1, 400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
